// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: FSM state encoding and a
//   helper that sizes the bit counter from the operand width.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // waiting for an operand set
    ST_SHIFT = 2'd1,  // adding one bit per cycle, LSB first
    ST_DONE  = 2'd2   // result presented until the consumer takes it
  } state_e;

  // One spare bit above clog2 so the counter can never wrap while it counts
  // up to WIDTH-1.
  function automatic int cnt_bits(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder; the only arithmetic in the serial adder.
//   Ports: a, b, c_in  - addend bits and carry in
//          s, c_out    - sum bit and carry out
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ c_in;
  assign c_out    = (a & b) | (c_in & half_sum);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder with valid/ready handshakes on both sides. An accepted
//   operand set is added LSB first, one bit per clock, through a single
//   full_adder; the result is held in DONE until the consumer accepts it.
//   Latency from accept edge to out_valid is WIDTH edges; throughput is one
//   operation per WIDTH+2 cycles.
//
//   Ports:
//     clk, rst            - clock, asynchronous active-high reset
//     in_valid / in_ready - operand handshake (ready only in IDLE)
//     a, b, c_in          - operands and carry in
//     out_valid/out_ready - result handshake (valid only in DONE)
//     s, c_out            - sum and carry out
//     busy                - high while bits are being added (SHIFT)
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             busy
);

  localparam int CNT_W = cnt_bits(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               fa_sum;
  logic               fa_carry;
  logic               last_bit;

  // Operands shift right, so bit 0 of each register is always the bit
  // currently being added.
  full_adder u_full_adder (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c_in  (carry_q),
    .s     (fa_sum),
    .c_out (fa_carry)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of every combinational block is
  // what keeps each path assigned and prevents latch inference.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (in_valid)  state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit)  state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (Moore)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_SHIFT);
  end

  assign s     = s_q;
  assign c_out = carry_q;

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        // New sum bit enters at the MSB; after WIDTH shifts the first bit
        // computed has reached bit 0. Written with shifts so WIDTH=1 works.
        s_d     = (s_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: ;  // DONE holds everything so s and c_out stay stable
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: these are plain flops, not a memory, so clearing them on reset is
  // cheap and makes s/c_out read zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Three serial_adder instances (WIDTH = 1, 8, 32) sharing clk/rst. Each
//   accepted operand set pushes its reference sum onto a scoreboard queue;
//   each result handshake pops and compares. Inputs change and outputs are
//   sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int NW = 3;
  localparam int W0 = 1;
  localparam int W1 = 8;
  localparam int W2 = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NW-1:0] in_valid_v, out_ready_v, c_in_v;
  wire  [NW-1:0] in_ready_v, out_valid_v, c_out_v, busy_v;
  logic [31:0]   a_v [NW];
  logic [31:0]   b_v [NW];
  wire  [W0-1:0] s_w0;
  wire  [W1-1:0] s_w1;
  wire  [W2-1:0] s_w2;
  logic [31:0]   s_v [NW];

  always_comb begin
    s_v[0] = 32'(s_w0);
    s_v[1] = 32'(s_w1);
    s_v[2] = s_w2;
  end

  serial_adder #(.WIDTH(W0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0][W0-1:0]), .b(b_v[0][W0-1:0]), .c_in(c_in_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .s(s_w0), .c_out(c_out_v[0]), .busy(busy_v[0])
  );

  serial_adder #(.WIDTH(W1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1][W1-1:0]), .b(b_v[1][W1-1:0]), .c_in(c_in_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .s(s_w1), .c_out(c_out_v[1]), .busy(busy_v[1])
  );

  serial_adder #(.WIDTH(W2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2]), .b(b_v[2]), .c_in(c_in_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .s(s_w2), .c_out(c_out_v[2]), .busy(busy_v[2])
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] sb [$];

  // ---------------------------------------------------------------------------
  // Reference model helpers
  // ---------------------------------------------------------------------------
  function automatic int width_of(input int k);
    case (k)
      0:       return W0;
      1:       return W1;
      default: return W2;
    endcase
  endfunction

  function automatic logic [31:0] op_mask(input int k);
    int w;
    w = width_of(k);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [32:0] ref_sum(input int k, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
    logic [32:0] t;
    t = {1'b0, a} + {1'b0, b} + {32'd0, c};
    return t & ((33'd1 << (width_of(k) + 1)) - 33'd1);
  endfunction

  function automatic logic [32:0] observed(input int k);
    return ({32'd0, c_out_v[k]} << width_of(k)) | {1'b0, s_v[k]};
  endfunction

  // Drive one operand set for a single cycle from a falling edge; the DUT is
  // expected to be idle, so the next rising edge accepts it.
  task automatic send(input int k, input logic [31:0] a, input logic [31:0] b,
                      input logic c);
    a_v[k]        = a & op_mask(k);
    b_v[k]        = b & op_mask(k);
    c_in_v[k]     = c;
    in_valid_v[k] = 1'b1;
    sb.push_back(ref_sum(k, a_v[k], b_v[k], c));
    @(negedge clk);
    in_valid_v[k] = 1'b0;
  endtask

  // Waits (bounded) for out_valid; lat counts rising edges after the accept.
  task automatic wait_valid(input int k, input int limit, output int lat);
    lat = 0;
    while (!out_valid_v[k] && lat < limit) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst         = 1'b1;
    in_valid_v  = '0;
    out_ready_v = '0;
    c_in_v      = '0;
    for (int k = 0; k < NW; k++) begin
      a_v[k] = '0;
      b_v[k] = '0;
    end
    #22;
    for (int k = 0; k < NW; k++) begin
      n_checks++;
      if ({in_ready_v[k], out_valid_v[k], busy_v[k]} !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_flags dut%0d got ready/valid/busy=%b exp=100", k,
                 {in_ready_v[k], out_valid_v[k], busy_v[k]});
      end
      n_checks++;
      if (observed(k) !== 33'd0) begin
        n_fail++;
        $display("FAIL reset_sum dut%0d got=%h exp=0", k, observed(k));
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    logic [32:0] exp;
    out_ready_v[1] = 1'b1;
    send(1, 32'hFF, 32'h01, 1'b0);
    wait_valid(1, 40, lat);
    n_checks++;
    if (lat !== W1) begin
      n_fail++;
      $display("FAIL basic_latency got=%0d exp=%0d", lat, W1);
    end
    exp = sb.pop_front();
    n_checks++;
    if (observed(1) !== exp) begin
      n_fail++;
      $display("FAIL basic_sum got=%h exp=%h", observed(1), exp);
    end
    @(negedge clk);
    n_checks++;
    if ({in_ready_v[1], out_valid_v[1]} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_return_idle got ready/valid=%b exp=10",
               {in_ready_v[1], out_valid_v[1]});
    end
  endtask

  task automatic test_busy();
    int lat;
    int busy_cnt;
    logic [32:0] exp;
    send(1, 32'hA5, 32'h5A, 1'b1);
    lat      = 0;
    busy_cnt = 0;
    while (!out_valid_v[1] && lat < 40) begin
      if (busy_v[1]) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (busy_cnt !== W1) begin
      n_fail++;
      $display("FAIL busy_cycles got=%0d exp=%0d", busy_cnt, W1);
    end
    exp = sb.pop_front();
    n_checks++;
    if (observed(1) !== exp || exp !== 33'h100) begin
      n_fail++;
      $display("FAIL busy_sum got=%h exp=%h", observed(1), 33'h100);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [32:0] exp;
    out_ready_v[1] = 1'b0;
    send(1, 32'h12, 32'h34, 1'b0);
    wait_valid(1, 40, lat);
    n_checks++;
    if (out_valid_v[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_timeout got out_valid=%b exp=1", out_valid_v[1]);
    end
    // Hold off the consumer while offering new operands that must be ignored.
    for (int i = 0; i < 20; i++) begin
      in_valid_v[1] = 1'b1;
      a_v[1]        = $urandom & op_mask(1);
      b_v[1]        = $urandom & op_mask(1);
      @(negedge clk);
      n_checks++;
      if ({out_valid_v[1], in_ready_v[1], observed(1)} !== {2'b10, 33'h046}) begin
        n_fail++;
        $display("FAIL bp_hold cycle%0d got valid/ready=%b sum=%h exp 10/046", i,
                 {out_valid_v[1], in_ready_v[1]}, observed(1));
      end
    end
    in_valid_v[1]  = 1'b0;
    out_ready_v[1] = 1'b1;
    exp = sb.pop_front();
    n_checks++;
    if (observed(1) !== exp) begin
      n_fail++;
      $display("FAIL bp_sum got=%h exp=%h", observed(1), exp);
    end
    @(negedge clk);
    n_checks++;
    if ({in_ready_v[1], out_valid_v[1]} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_release got ready/valid=%b exp=10",
               {in_ready_v[1], out_valid_v[1]});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int pulses;
    logic [32:0] exp;
    send(1, 32'h55, 32'h11, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    n_checks++;
    if ({in_ready_v[1], out_valid_v[1], busy_v[1], observed(1)} !== {3'b100, 33'd0}) begin
      n_fail++;
      $display("FAIL midrst_immediate got ready/valid/busy=%b sum=%h exp 100/0",
               {in_ready_v[1], out_valid_v[1], busy_v[1]}, observed(1));
    end
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid_v[1]) pulses++;
      @(negedge clk);
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL midrst_no_pulse got=%0d exp=0", pulses);
    end
    send(1, 32'h03, 32'h04, 1'b0);
    wait_valid(1, 40, lat);
    exp = sb.pop_front();
    n_checks++;
    if (observed(1) !== exp || !out_valid_v[1]) begin
      n_fail++;
      $display("FAIL midrst_next_sum got=%h valid=%b exp=%h", observed(1),
               out_valid_v[1], exp);
    end
    @(negedge clk);
  endtask

  task automatic test_input_ignore();
    int lat;
    logic [32:0] exp;
    send(1, 32'h3C, 32'h0F, 1'b1);
    lat = 0;
    while (!out_valid_v[1] && lat < 40) begin
      in_valid_v[1] = 1'b1;
      a_v[1]        = $urandom & op_mask(1);
      b_v[1]        = $urandom & op_mask(1);
      c_in_v[1]     = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid_v[1] = 1'b0;
    exp = sb.pop_front();
    n_checks++;
    if (observed(1) !== exp || !out_valid_v[1]) begin
      n_fail++;
      $display("FAIL ignore_sum got=%h valid=%b exp=%h", observed(1),
               out_valid_v[1], exp);
    end
    @(negedge clk);
  endtask

  // in_valid held high: accepts must be spaced exactly WIDTH+2 cycles apart.
  task automatic test_back_to_back(input int k);
    int cyc;
    int n_acc;
    int last_acc;
    logic [32:0] exp;
    out_ready_v[k] = 1'b1;
    cyc      = 0;
    n_acc    = 0;
    last_acc = -1;
    while ((n_acc < 4 || sb.size() > 0) && cyc < 400) begin
      if (in_ready_v[k] && n_acc < 4) begin
        a_v[k]        = $urandom & op_mask(k);
        b_v[k]        = $urandom & op_mask(k);
        c_in_v[k]     = 1'($urandom);
        in_valid_v[k] = 1'b1;
        sb.push_back(ref_sum(k, a_v[k], b_v[k], c_in_v[k]));
        if (last_acc >= 0) begin
          n_checks++;
          if (cyc - last_acc !== width_of(k) + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing dut%0d got=%0d exp=%0d", k,
                     cyc - last_acc, width_of(k) + 2);
          end
        end
        last_acc = cyc;
        n_acc++;
      end else if (in_ready_v[k]) begin
        in_valid_v[k] = 1'b0;
      end
      if (out_valid_v[k] && sb.size() > 0) begin
        exp = sb.pop_front();
        n_checks++;
        if (observed(k) !== exp) begin
          n_fail++;
          $display("FAIL b2b_sum dut%0d got=%h exp=%h", k, observed(k), exp);
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid_v[k] = 1'b0;
    n_checks++;
    if (n_acc !== 4 || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_timeout dut%0d got accepts=%0d pending=%0d exp 4/0", k,
               n_acc, sb.size());
    end
  endtask

  task automatic test_random(input int k, input int n_ops);
    int cyc;
    int n_acc;
    int limit;
    logic [32:0] exp;
    cyc   = 0;
    n_acc = 0;
    limit = n_ops * (width_of(k) + 2) * 6 + 100;
    while ((n_acc < n_ops || sb.size() > 0) && cyc < limit) begin
      out_ready_v[k] = ($urandom_range(0, 3) != 0);
      if (n_acc < n_ops && $urandom_range(0, 3) != 0) begin
        in_valid_v[k] = 1'b1;
        a_v[k]        = $urandom & op_mask(k);
        b_v[k]        = $urandom & op_mask(k);
        c_in_v[k]     = 1'($urandom);
      end else begin
        in_valid_v[k] = 1'b0;
      end
      if (in_valid_v[k] && in_ready_v[k]) begin
        sb.push_back(ref_sum(k, a_v[k], b_v[k], c_in_v[k]));
        n_acc++;
      end
      if (out_valid_v[k] && out_ready_v[k]) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rand_unexpected dut%0d got=%h exp=none", k, observed(k));
        end else begin
          exp = sb.pop_front();
          n_checks++;
          if (observed(k) !== exp) begin
            n_fail++;
            $display("FAIL rand_sum dut%0d got=%h exp=%h", k, observed(k), exp);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid_v[k]  = 1'b0;
    out_ready_v[k] = 1'b1;
    n_checks++;
    if (n_acc !== n_ops || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL rand_timeout dut%0d got accepts=%0d pending=%0d exp %0d/0",
               k, n_acc, sb.size(), n_ops);
    end
    sb.delete();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_busy();
    test_backpressure();
    test_reset_mid();
    test_input_ignore();
    test_back_to_back(1);
    test_back_to_back(0);
    test_random(0, 334);
    test_random(1, 333);
    test_random(2, 333);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
